// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint; SCK, CS_n and MOSI are oversampled in i_Clk.
// Define SPI_PERIPH_MISO_TRISTATE_EN to float MISO outside a frame.
module spi_peripheral #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_CS_Active,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;
    logic [2:0] sck_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_hold;
    logic       tx_valid;
    logic       load_pend;
    logic       load;

    // Synchronizers stay live through reset so CS_n is tracked across it
    always_ff @(posedge i_Clk) begin
        sck_sync  <= {sck_sync[1:0], i_SPI_Clk};
        cs_sync   <= {cs_sync[1:0], i_SPI_CS_n};
        mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
    end

    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign cs_rise     = cs_sync[1] & ~cs_sync[2];
    assign cs_fall     = ~cs_sync[1] & cs_sync[2];
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    always_comb begin
        load = 1'b0;
        if (state == IDLE && cs_fall)
            load = ~CPHA;
        else if (state == ACTIVE && !cs_rise && shift_edge)
            load = load_pend;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= WAIT_IDLE;
            o_CS_Active <= 1'b0;
            bit_cnt     <= 3'd7;
            rx_shift    <= 7'h00;
            o_RX_Byte   <= 8'h00;
            o_RX_DV     <= 1'b0;
            load_pend   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            unique case (state)
                WAIT_IDLE: begin
                    if (cs_sync[1])
                        state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        o_CS_Active <= 1'b1;
                        bit_cnt     <= 3'd7;
                        load_pend   <= CPHA;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        o_CS_Active <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                        bit_cnt  <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            o_RX_Byte <= {rx_shift, mosi_sync[1]};
                            o_RX_DV   <= 1'b1;
                            load_pend <= 1'b1;
                        end
                    end else if (shift_edge) begin
                        load_pend <= 1'b0;
                    end
                end
                default: begin
                    state       <= WAIT_IDLE;
                    o_CS_Active <= 1'b0;
                end
            endcase
        end
    end

    // A same-cycle i_TX_DV lands after the load has taken the old content
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_hold  <= 8'h00;
            tx_valid <= 1'b0;
            tx_shift <= 8'h00;
        end else begin
            if (load)
                tx_shift <= tx_valid ? tx_hold : 8'h00;
            else if (state == ACTIVE && shift_edge)
                tx_shift <= {tx_shift[6:0], 1'b0};
            else if (state == IDLE && cs_fall)
                tx_shift <= 8'h00;
            if (load)
                tx_valid <= 1'b0;
            if (i_TX_DV && !tx_valid) begin
                tx_hold  <= i_TX_Byte;
                tx_valid <= 1'b1;
            end
        end
    end

    assign o_TX_Ready = ~tx_valid;

`ifdef SPI_PERIPH_MISO_TRISTATE_EN
    assign o_SPI_MISO = o_CS_Active ? tx_shift[7] : 1'bz;
`else
    assign o_SPI_MISO = o_CS_Active ? tx_shift[7] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: one instance per SPI mode, driven by a
// behavioural SPI controller and checked against a byte-level model.
module tb_spi_peripheral;

    localparam int HALF = 8;
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic [3:0] mosi;
    logic [3:0] miso;
    logic [3:0] tx_dv;
    logic [3:0] tx_ready;
    logic [3:0] rx_dv;
    logic [3:0] cs_active;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
    logic [9:0] got_q [$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_peripheral #(.SPI_MODE(g)) dut (
            .i_Clk      (clk),
            .i_Rst      (rst),
            .i_TX_Byte  (tx_byte[g]),
            .i_TX_DV    (tx_dv[g]),
            .o_TX_Ready (tx_ready[g]),
            .o_RX_DV    (rx_dv[g]),
            .o_RX_Byte  (rx_byte[g]),
            .o_CS_Active(cs_active[g]),
            .i_SPI_Clk  (sck[g]),
            .i_SPI_CS_n (cs_n[g]),
            .i_SPI_MOSI (mosi[g]),
            .o_SPI_MISO (miso[g])
        );
    end

    // Every cycle with RX_DV high records one received byte
    always @(negedge clk)
        for (int m = 0; m < 4; m++)
            if (rx_dv[m])
                got_q.push_back({2'(m), rx_byte[m]});

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input int m, input logic [7:0] b);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        wait_cyc(1);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic wait_ready(input int m, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (tx_ready[m]) begin
                ok = 1'b1;
                break;
            end
            wait_cyc(1);
        end
    endtask

    // Controller side of the bus: drives MOSI, returns what it read on MISO
    task automatic xfer_bits(input int m, input logic [7:0] mo,
                             input int nbits, output logic [7:0] mi);
        logic cpol;
        logic cpha;
        cpol = m[1];
        cpha = m[0];
        mi   = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi[m] = mo[i];
                wait_cyc(HALF);
                mi[i]   = miso[m];
                sck[m]  = ~cpol;
                wait_cyc(HALF);
                sck[m]  = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = mo[i];
                wait_cyc(HALF);
                mi[i]   = miso[m];
                sck[m]  = cpol;
                wait_cyc(HALF);
            end
        end
    endtask

    task automatic frame_start(input int m);
        cs_n[m] = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame_end(input int m);
        wait_cyc(HALF);
        cs_n[m] = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic check_reset(input int m);
        check($sformatf("rst_ready m%0d", m), tx_ready[m], 1'b1);
        check($sformatf("rst_rxdv m%0d", m), rx_dv[m], 1'b0);
        check($sformatf("rst_rxbyte m%0d", m), rx_byte[m], 8'h00);
        check($sformatf("rst_csact m%0d", m), cs_active[m], 1'b0);
        check($sformatf("rst_miso m%0d", m), miso[m], IDLE_MISO);
    endtask

    // Model: slot k returns tx[k] for k < cnt, else underrun 00
    task automatic run_frame(input int m, input int n,
                             input logic [7:0] mo [3],
                             input logic [7:0] tx [3],
                             input int cnt, input bit pre);
        logic [7:0] mi;
        logic [7:0] exp_miso [3];
        bit         ok;
        got_q.delete();
        for (int k = 0; k < 3; k++)
            exp_miso[k] = (k < cnt) ? tx[k] : 8'h00;
        if (cnt > 0 && !pre) begin
            push_tx(m, tx[0]);
            check("ready_low", tx_ready[m], 1'b0);
        end
        fork
            begin
                frame_start(m);
                check($sformatf("cs_active m%0d", m), cs_active[m], 1'b1);
                for (int k = 0; k < n; k++) begin
                    xfer_bits(m, mo[k], 8, mi);
                    check($sformatf("miso m%0d b%0d", m, k), mi,
                          exp_miso[k]);
                end
                frame_end(m);
            end
            begin
                for (int k = 1; k < cnt; k++) begin
                    wait_ready(m, ok);
                    check("feed_ready", ok, 1'b1);
                    push_tx(m, tx[k]);
                end
            end
        join
        check($sformatf("cs_idle m%0d", m), cs_active[m], 1'b0);
        check($sformatf("ready_high m%0d", m), tx_ready[m], 1'b1);
        check($sformatf("idle_miso m%0d", m), miso[m], IDLE_MISO);
        check($sformatf("rx_count m%0d", m), got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++)
            check($sformatf("rx_byte m%0d b%0d", m, k), got_q[k],
                  {m[1:0], mo[k]});
    endtask

    initial begin
        logic [7:0] mi;
        rst  = 1'b1;
        sck  = 4'b1100;
        cs_n = 4'hF;
        mosi = 4'h0;
        tx_dv = 4'h0;
        for (int m = 0; m < 4; m++)
            tx_byte[m] = 8'h00;
        wait_cyc(5);
        for (int m = 0; m < 4; m++)
            check_reset(m);
        rst = 1'b0;
        wait_cyc(5);

        run_frame(0, 1, '{8'hA5, 8'h00, 8'h00},
                  '{8'h3C, 8'h00, 8'h00}, 1, 1'b0);
        run_frame(3, 2, '{8'h12, 8'h34, 8'h00},
                  '{8'hDE, 8'hAD, 8'h00}, 2, 1'b0);
        run_frame(0, 1, '{8'hFF, 8'h00, 8'h00},
                  '{8'h00, 8'h00, 8'h00}, 0, 1'b0);

        // i_TX_DV while the holding register is full is dropped
        push_tx(1, 8'h3C);
        check("ready_full", tx_ready[1], 1'b0);
        push_tx(1, 8'h99);
        run_frame(1, 2, '{8'hA5, 8'h5A, 8'h00},
                  '{8'h3C, 8'h00, 8'h00}, 1, 1'b1);

        // i_TX_DV in the CS-assert load cycle: load sees empty holding
        got_q.delete();
        cs_n[0] = 1'b0;
        wait_cyc(2);
        check("cs_latency_2", cs_active[0], 1'b0);
        push_tx(0, 8'hC3);
        check("cs_latency_3", cs_active[0], 1'b1);
        check("collide_ready", tx_ready[0], 1'b0);
        wait_cyc(HALF);
        xfer_bits(0, 8'h6E, 8, mi);
        check("collide_b0", mi, 8'h00);
        xfer_bits(0, 8'h91, 8, mi);
        check("collide_b1", mi, 8'hC3);
        frame_end(0);
        check("collide_rx_n", got_q.size(), 2);

        for (int m = 0; m < 4; m++) begin
            got_q.delete();
            frame_start(m);
            xfer_bits(m, 8'hFF, 5, mi);
            frame_end(m);
            check($sformatf("abort_no_dv m%0d", m), got_q.size(), 0);
            run_frame(m, 1, '{8'h81, 8'h00, 8'h00},
                      '{8'h00, 8'h00, 8'h00}, 0, 1'b0);
        end

        for (int it = 0; it < 16; it++) begin
            int         m;
            int         n;
            int         cnt;
            logic [7:0] mo [3];
            logic [7:0] tx [3];
            m   = $urandom_range(0, 3);
            n   = $urandom_range(1, 3);
            cnt = $urandom_range(0, n);
            for (int k = 0; k < 3; k++) begin
                mo[k] = 8'($urandom);
                tx[k] = 8'($urandom);
            end
            run_frame(m, n, mo, tx, cnt, 1'b0);
        end

        // Reset mid-frame with CS_n held low must not rejoin that frame
        run_frame(0, 1, '{8'hB7, 8'h00, 8'h00},
                  '{8'h00, 8'h00, 8'h00}, 0, 1'b0);
        got_q.delete();
        frame_start(0);
        xfer_bits(0, 8'hF0, 4, mi);
        rst = 1'b1;
        wait_cyc(3);
        check_reset(0);
        rst = 1'b0;
        xfer_bits(0, 8'hFF, 8, mi);
        xfer_bits(0, 8'h0F, 4, mi);
        check("rst_no_dv", got_q.size(), 0);
        check("rst_wait", cs_active[0], 1'b0);
        check("rst_wait_miso", miso[0], IDLE_MISO);
        frame_end(0);
        run_frame(0, 1, '{8'h5A, 8'h00, 8'h00},
                  '{8'h66, 8'h00, 8'h00}, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
